// File: rtl/watch_calendar.sv
// Calendar counter: year/month/day plus weekday, one day per en_day strobe, with validated loads.
// Optional Gregorian leap-year support via `WATCH_CAL_LEAP_EN (undefined: February is always 28 days).
module watch_calendar #(
  parameter int YEAR_W    = 12,
  parameter int YEAR_MIN  = 1,
  parameter int YEAR_MAX  = 2**YEAR_W-1,
  parameter int DOW_RESET = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_day,
  input  logic              set_date,
  input  logic [YEAR_W+8:0] bin_date,
  input  logic [2:0]        set_dow,
  output logic [YEAR_W-1:0] year,
  output logic [3:0]        month,
  output logic [4:0]        day,
  output logic [2:0]        dow,
  output logic              set_err,
  output logic              year_wrap
);

  localparam logic [YEAR_W-1:0] YMIN   = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0] YONE   = YEAR_W'(1);
  localparam logic [31:0]       YMIN32 = 32'(YEAR_MIN);
  localparam logic [31:0]       YMAX32 = 32'(YEAR_MAX);
  localparam logic [2:0]        DOW0   = 3'(DOW_RESET);

  function automatic logic [4:0] max_day(input logic leap, input logic [3:0] m);
    case (m)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: max_day = 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                    max_day = 5'd30;
      4'd2:                                       max_day = leap ? 5'd29 : 5'd28;
      default:                                    max_day = 5'd0;
    endcase
  endfunction

  logic [YEAR_W-1:0] ld_year;
  logic [3:0]        ld_month;
  logic [4:0]        ld_day;
  logic              leap_cur, leap_ld;
  logic              ld_ok;
  logic              last_day, last_month, last_year;

  assign ld_year  = bin_date[YEAR_W+8:9];
  assign ld_month = bin_date[8:5];
  assign ld_day   = bin_date[4:0];

`ifdef WATCH_CAL_LEAP_EN
  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    logic [31:0] v;
    v = 32'(y);
    is_leap = ((v % 32'd4) == 32'd0) &&
              (((v % 32'd100) != 32'd0) || ((v % 32'd400) == 32'd0));
  endfunction

  assign leap_cur = is_leap(year);
  assign leap_ld  = is_leap(ld_year);
`else
  assign leap_cur = 1'b0;
  assign leap_ld  = 1'b0;
`endif

  // An out-of-range month yields max_day 0, which rejects every day value.
  assign ld_ok = (32'(ld_year) >= YMIN32) && (32'(ld_year) <= YMAX32) &&
                 (ld_month >= 4'd1) && (ld_month <= 4'd12) &&
                 (ld_day != 5'd0) && (ld_day <= max_day(leap_ld, ld_month)) &&
                 (set_dow <= 3'd6);

  assign last_day   = (day >= max_day(leap_cur, month));
  assign last_month = (month >= 4'd12);
  assign last_year  = (32'(year) >= YMAX32);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      year      <= YMIN;
      month     <= 4'd1;
      day       <= 5'd1;
      dow       <= DOW0;
      set_err   <= 1'b0;
      year_wrap <= 1'b0;
    end else begin
      set_err   <= 1'b0;
      year_wrap <= 1'b0;
      if (set_date) begin
        // A strobe coinciding with a load is dropped, not deferred.
        if (ld_ok) begin
          year  <= ld_year;
          month <= ld_month;
          day   <= ld_day;
          dow   <= set_dow;
        end else begin
          set_err <= 1'b1;
        end
      end else if (en_day) begin
        dow <= (dow == 3'd6) ? 3'd0 : dow + 3'd1;
        if (!last_day) begin
          day <= day + 5'd1;
        end else begin
          day <= 5'd1;
          if (!last_month) begin
            month <= month + 4'd1;
          end else begin
            month <= 4'd1;
            if (!last_year) begin
              year <= year + YONE;
            end else begin
              year      <= YMIN;
              year_wrap <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
